// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared types and constants for the UART transmit path:
//                controller state encoding, frame-mux select codes and the
//                default payload width.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Controller states. Explicit 3-bit encoding so that state values are
    // stable across tools and visible in waveforms.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Frame mux select codes.
    localparam logic [1:0] MUX_START = 2'b00;  // line driven low
    localparam logic [1:0] MUX_IDLE  = 2'b01;  // line driven high (idle / stop)
    localparam logic [1:0] MUX_DATA  = 2'b10;  // serializer output
    localparam logic [1:0] MUX_PAR   = 2'b11;  // parity bit

endpackage
`default_nettype wire

// File: rtl/uart_parity_calc.sv
`default_nettype none
// ============================================================================
//  Module      : uart_parity_calc
//  Description : Combinational UART parity generator, shared by the TX
//                controller and the RX checker.
//                par_typ = 0 -> even parity, par_typ = 1 -> odd parity.
//  Ports       : data    [DATA_WIDTH] in  payload
//                par_typ              in  parity type
//                par_bit              out parity bit to transmit / expect
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (^data) ^ par_typ;

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_ctrl
//  Description : Sequencing controller for the UART transmit path. Accepts
//                bytes from the system side, drives the serializer load/shift
//                controls, the frame-mux select and the parity bit.
//                Frame: start, DATA_WIDTH data bits LSB first, optional
//                parity, one stop bit. One bit per clk cycle.
//  Build macro : UART_TX_HOLD_EN - adds a one-entry holding register so a
//                request arriving mid-frame is queued instead of dropped.
//  Ports       : clk, rst (sync, active high)
//                P_Data/Data_valid/PAR_EN/PAR_TYP  request side
//                ser_done                          from serializer
//                ser_load/ser_pdata/ser_en         to serializer
//                mux_sel/par_bit                   to frame mux
//                BUSY/hold_full/tx_ovf             status
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic                  Data_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    output logic                  ser_load,
    output logic [DATA_WIDTH-1:0] ser_pdata,
    output logic                  ser_en,
    output logic [1:0]            mux_sel,
    output logic                  par_bit,
    output logic                  BUSY,
    output logic                  hold_full,
    output logic                  tx_ovf
);

    tx_state_t             r_state;
    tx_state_t             w_next_state;

    logic                  r_par_en;
    logic                  r_par_bit;

    logic                  w_direct;      // request accepted straight from IDLE
    logic                  w_drop;        // request discarded
    logic                  w_launch;      // a frame starts next cycle
    logic [DATA_WIDTH-1:0] w_launch_data;
    logic                  w_launch_en;
    logic                  w_launch_typ;
    logic                  w_par_calc;

`ifdef UART_TX_HOLD_EN
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_hold_en;
    logic                  r_hold_typ;
    logic                  r_hold_full;
    logic                  w_drain;
    logic                  w_capture;

    // The hold is emptied at a frame boundary (STOP, or IDLE when a byte was
    // captured during the final stop cycle). A held byte always has priority
    // over a fresh request; the fresh one then takes the freed slot.
    assign w_drain   = ((r_state == IDLE) || (r_state == STOP)) && r_hold_full;
    assign w_direct  = (r_state == IDLE) && !r_hold_full && Data_valid;
    assign w_capture = Data_valid && !w_direct && (!r_hold_full || w_drain);
    assign w_drop    = Data_valid && !w_direct && r_hold_full && !w_drain;
    assign w_launch  = w_drain || w_direct;

    assign w_launch_data = w_drain ? r_hold_data : P_Data;
    assign w_launch_en   = w_drain ? r_hold_en   : PAR_EN;
    assign w_launch_typ  = w_drain ? r_hold_typ  : PAR_TYP;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
            r_hold_en   <= 1'b0;
            r_hold_typ  <= 1'b0;
        end else if (w_capture) begin
            r_hold_full <= 1'b1;
            r_hold_data <= P_Data;
            r_hold_en   <= PAR_EN;
            r_hold_typ  <= PAR_TYP;
        end else if (w_drain) begin
            r_hold_full <= 1'b0;
        end
    end

    assign hold_full = r_hold_full;
`else
    assign w_direct      = (r_state == IDLE) && Data_valid;
    assign w_drop        = (r_state != IDLE) && Data_valid;
    assign w_launch      = w_direct;
    assign w_launch_data = P_Data;
    assign w_launch_en   = PAR_EN;
    assign w_launch_typ  = PAR_TYP;
    assign hold_full     = 1'b0;
`endif

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (w_launch_data),
        .par_typ (w_launch_typ),
        .par_bit (w_par_calc)
    );

    // Load strobe and overflow are combinational with the request; they are
    // masked during reset so an abandoned cycle never loads or flags.
    assign ser_load  = w_launch && !rst;
    assign ser_pdata = ser_load ? w_launch_data : '0;
    assign tx_ovf    = w_drop && !rst;
    assign BUSY      = (r_state != IDLE);
    assign par_bit   = r_par_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Parity configuration is frozen per frame at launch time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_launch) begin
            r_par_en  <= w_launch_en;
            r_par_bit <= w_par_calc;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ser_en       = 1'b0;
        mux_sel      = MUX_IDLE;
        case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_next_state = START;
                end
            end
            START: begin
                mux_sel      = MUX_START;
                w_next_state = DATA;
            end
            DATA: begin
                ser_en  = 1'b1;
                mux_sel = MUX_DATA;
                if (ser_done) begin
                    w_next_state = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                mux_sel      = MUX_PAR;
                w_next_state = STOP;
            end
            STOP: begin
                w_next_state = w_launch ? START : IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_ctrl
//  Description : Self-checking bench for uart_tx_ctrl with a serializer
//                model, a frame-level reference model, a vector table and
//                directed corner-case sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

`ifdef UART_TX_HOLD_EN
    localparam bit HOLD_BUILD = 1'b1;
`else
    localparam bit HOLD_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] P_Data = 8'h00;
    logic       Data_valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       ser_done;
    logic       ser_load;
    logic [7:0] ser_pdata;
    logic       ser_en;
    logic [1:0] mux_sel;
    logic       par_bit;
    logic       BUSY;
    logic       hold_full;
    logic       tx_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_Data     (P_Data),
        .Data_valid (Data_valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_done   (ser_done),
        .ser_load   (ser_load),
        .ser_pdata  (ser_pdata),
        .ser_en     (ser_en),
        .mux_sel    (mux_sel),
        .par_bit    (par_bit),
        .BUSY       (BUSY),
        .hold_full  (hold_full),
        .tx_ovf     (tx_ovf)
    );

    // ---------------- serializer model ----------------
    logic [7:0] s_shreg = 8'h00;
    int         s_cnt = 0;
    logic       spur = 1'b0;     // stray done pulses outside the data phase
    logic       line;

    always @(posedge clk) begin
        if (ser_load)    s_shreg <= ser_pdata;
        else if (ser_en) s_shreg <= s_shreg >> 1;
        if (ser_en) s_cnt <= s_cnt + 1;
        else        s_cnt <= 0;
    end
    assign ser_done = ser_en ? (s_cnt == 7) : spur;
    assign line = (mux_sel == 2'b00) ? 1'b0 :
                  (mux_sel == 2'b01) ? 1'b1 :
                  (mux_sel == 2'b10) ? s_shreg[0] : par_bit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    typedef struct { logic [1:0] mux; logic ln; } slot_t;
    slot_t      fq[$];           // remaining bit slots of the frame on the line
    logic       m_hold_v = 1'b0;
    logic [7:0] m_hold_d = 8'h00;
    logic       m_hold_en = 1'b0;
    logic       m_hold_typ = 1'b0;
    logic       m_par = 1'b0;

    task automatic model_step();
        logic busy, boundary, launch, from_hold, cap, e_ovf, l_en, l_typ;
        logic [7:0] ld;
        slot_t s;
        if (rst) begin
            fq.delete();
            m_hold_v = 1'b0;
            m_par    = 1'b0;
            return;
        end
        busy = (fq.size() != 0);
        boundary = !busy || (fq.size() == 1);
        launch = 0; from_hold = 0; cap = 0; e_ovf = 0; ld = 0; l_en = 0; l_typ = 0;
        if (HOLD_BUILD && boundary && m_hold_v) begin
            launch = 1; from_hold = 1; cap = Data_valid;
            ld = m_hold_d; l_en = m_hold_en; l_typ = m_hold_typ;
        end else if (!busy && Data_valid) begin
            launch = 1; ld = P_Data; l_en = PAR_EN; l_typ = PAR_TYP;
        end else if (Data_valid) begin
            if (HOLD_BUILD && !m_hold_v) cap = 1;
            else e_ovf = 1;
        end
        chk("m_busy", BUSY, busy);
        chk("m_mux", mux_sel, busy ? fq[0].mux : 2'b01);
        chk("m_line", line, busy ? fq[0].ln : 1'b1);
        chk("m_ser_en", ser_en, busy && (fq[0].mux == 2'b10));
        chk("m_par_bit", par_bit, m_par);
        chk("m_hold_full", hold_full, m_hold_v);
        chk("m_tx_ovf", tx_ovf, e_ovf);
        chk("m_ser_load", ser_load, launch);
        chk("m_ser_pdata", ser_pdata, launch ? ld : 8'h00);
        if (busy) void'(fq.pop_front());
        if (launch) begin
            s.mux = 2'b00; s.ln = 1'b0; fq.push_back(s);
            for (int i = 0; i < 8; i++) begin
                s.mux = 2'b10; s.ln = ld[i]; fq.push_back(s);
            end
            if (l_en) begin
                s.mux = 2'b11; s.ln = (^ld) ^ l_typ; fq.push_back(s);
            end
            s.mux = 2'b01; s.ln = 1'b1; fq.push_back(s);
            m_par = (^ld) ^ l_typ;
        end
        if (from_hold) m_hold_v = cap;
        else if (cap) m_hold_v = 1'b1;
        if (cap) begin
            m_hold_d = P_Data; m_hold_en = PAR_EN; m_hold_typ = PAR_TYP;
        end
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; request held for one cycle, overflow sampled mid-cycle.
    task automatic drive_req(input logic [7:0] d, input logic en, input logic typ, output logic ovf);
        P_Data = d; PAR_EN = en; PAR_TYP = typ; Data_valid = 1'b1;
        @(negedge clk);
        ovf = tx_ovf;
        tick();
        Data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!BUSY && !hold_full) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_reached", ok, 1'b1);
        tick();
    endtask

    // Starts in the START cycle; records the frame as seen on the line.
    task automatic measure(output int len, output logic [10:0] lw, output logic pb, output logic [1:0] m9);
        len = 0; lw = '0; pb = 1'b0; m9 = 2'b00;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (BUSY) begin
                if (len < 11) lw[len] = line;
                if (len == 0) pb = par_bit;
                if (len == 9) m9 = mux_sel;
                len++;
            end
        end
        tick();
    endtask

    typedef struct {
        logic [7:0]  d;
        logic        en;
        logic        typ;
        int          len;
        logic [10:0] lw;    // bit k = line level in frame cycle k
        logic        par;
        logic [1:0]  m9;
    } vec_t;
    vec_t vt[6];

    initial begin
        int          len;
        logic [10:0] lw;
        logic        pb, ov, ov2, ov3;
        logic [1:0]  m9, after_mux;
        logic        got_stop, have_after, stop_load, ovf_seen;

        vt[0] = '{8'hA5, 1'b0, 1'b0, 10, 11'h34A, 1'b0, 2'b01};
        vt[1] = '{8'hA5, 1'b1, 1'b0, 11, 11'h54A, 1'b0, 2'b11};
        vt[2] = '{8'hA5, 1'b1, 1'b1, 11, 11'h74A, 1'b1, 2'b11};
        vt[3] = '{8'h00, 1'b1, 1'b1, 11, 11'h600, 1'b1, 2'b11};
        vt[4] = '{8'hFF, 1'b0, 1'b0, 10, 11'h3FE, 1'b0, 2'b01};
        vt[5] = '{8'h01, 1'b1, 1'b0, 11, 11'h602, 1'b1, 2'b11};

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mux", mux_sel, 2'b01);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_ser_en", ser_en, 1'b0);
        chk("rst_ser_load", ser_load, 1'b0);
        chk("rst_tx_ovf", tx_ovf, 1'b0);
        chk("rst_hold_full", hold_full, 1'b0);
        chk("rst_par_bit", par_bit, 1'b0);
        chk("rst_ser_pdata", ser_pdata, 8'h00);
        tick();

        // Table-driven single frames.
        for (int v = 0; v < 6; v++) begin
            wait_idle();
            drive_req(vt[v].d, vt[v].en, vt[v].typ, ov);
            measure(len, lw, pb, m9);
            chk($sformatf("vec%0d_len", v), len, vt[v].len);
            chk($sformatf("vec%0d_line", v), lw, vt[v].lw);
            chk($sformatf("vec%0d_par", v), pb, vt[v].par);
            chk($sformatf("vec%0d_mux9", v), m9, vt[v].m9);
        end

        // Parity config changed mid-frame must not affect the frame in flight.
        wait_idle();
        drive_req(8'hA5, 1'b1, 1'b0, ov);
        PAR_EN = 1'b0; PAR_TYP = 1'b1;
        measure(len, lw, pb, m9);
        chk("cfg_hold_len", len, 11);
        chk("cfg_hold_par", pb, 1'b0);
        chk("cfg_hold_mux9", m9, 2'b11);

        // Second byte during frame cycle 4: queued and loaded in STOP (hold build).
        wait_idle();
        drive_req(8'h3C, 1'b0, 1'b0, ov);
        tick(); tick(); tick();
        drive_req(8'hC3, 1'b0, 1'b0, ov);
        ovf_seen = ov; got_stop = 0; have_after = 0; stop_load = 0; after_mux = 2'b11;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx_ovf) ovf_seen = 1'b1;
            if (got_stop && !have_after) begin
                after_mux = mux_sel;
                have_after = 1'b1;
            end
            if (!got_stop && BUSY && mux_sel == 2'b01) begin
                got_stop = 1'b1;
                stop_load = ser_load && (ser_pdata == 8'hC3);
            end
        end
        tick();
        chk("b2b_stop_load", stop_load, HOLD_BUILD);
        chk("b2b_next_mux", after_mux, HOLD_BUILD ? 2'b00 : 2'b01);
        chk("b2b_ovf", ovf_seen, !HOLD_BUILD);

        // Three requests in one frame.
        wait_idle();
        drive_req(8'h11, 1'b0, 1'b0, ov);
        tick();
        drive_req(8'h22, 1'b1, 1'b0, ov2);
        drive_req(8'h33, 1'b0, 1'b1, ov3);
        chk("three_req_ovf2", ov2, !HOLD_BUILD);
        chk("three_req_ovf3", ov3, 1'b1);

        // Reset in the fifth data cycle with a byte held.
        wait_idle();
        drive_req(8'h5A, 1'b1, 1'b0, ov);
        tick();
        drive_req(8'h77, 1'b0, 1'b0, ov);
        tick(); tick(); tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pos_mux", mux_sel, 2'b10);
        chk("midrst_ovf", tx_ovf, 1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_mux", mux_sel, 2'b01);
        chk("midrst_ser_en", ser_en, 1'b0);
        chk("midrst_hold", hold_full, 1'b0);
        chk("midrst_busy", BUSY, 1'b0);
        tick();

        // Randomised traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            Data_valid = ($urandom_range(0, 2) == 0);
            P_Data     = 8'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
            spur       = 1'($urandom);
            tick();
        end
        rst = 1'b0; Data_valid = 1'b0; spur = 1'b0;
        wait_idle();
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Sequencing controller for the UART transmit path. It accepts parallel bytes from the system side and drives the 8-bit serializer's load and shift controls. It also produces the frame-mux select (start / data / parity / stop) and the parity bit. Frames are start, 8 data bits LSB-first, optional parity, and one stop bit. One bit is sent per `clk` cycle, so `clk` is the TX bit-rate clock.

## Interface
- `DATA_WIDTH`, 8, payload width; must equal the serializer width and its `ser_done` count.
- `clk`  in  1  TX bit clock.
- `rst`  in  1  synchronous, active-high reset.
- `P_Data`  in  DATA_WIDTH  byte to send; sampled when `Data_valid`=1.
- `Data_valid`  in  1  single-cycle request strobe.
- `PAR_EN`  in  1  parity bit inserted when 1; sampled at acceptance.
- `PAR_TYP`  in  1  0 = even, 1 = odd; sampled at acceptance.
- `ser_done`  in  1  from serializer; high in the last data-bit cycle.
- `ser_load`  out  1  serializer load strobe (wired to the serializer's `Data_valid`; serializer `BUSY` tied 0).
- `ser_pdata`  out  DATA_WIDTH  byte presented with `ser_load`.
- `ser_en`  out  1  serializer shift enable.
- `mux_sel`  out  2  frame mux select: 00 start(0), 01 idle/stop(1), 10 ser_data, 11 parity.
- `par_bit`  out  1  parity of the frame in flight.
- `BUSY`  out  1  frame in progress.
- `hold_full`  out  1  holding register occupied (0 when the hold buffer is compiled out).
- `tx_ovf`  out  1  one-cycle pulse when a request is dropped.

## Operation
- States:
  - IDLE: `mux_sel`=01.
  - START: `mux_sel`=00.
  - DATA: `ser_en`=1, `mux_sel`=10.
  - PARITY: `mux_sel`=11.
  - STOP: `mux_sel`=01.
- IDLE with `Data_valid`=1: `ser_load`=1 and `ser_pdata`=`P_Data` in the same cycle (combinational). The controller latches the parity config and computes `par_bit` = ^`P_Data` XOR `PAR_TYP`, then moves to START.
- START moves to DATA after 1 cycle.
- DATA: `ser_en` is held. On `ser_done`=1, go to PARITY if the latched PAR_EN is 1, else STOP. DATA lasts exactly 8 cycles.
- PARITY moves to STOP after 1 cycle.
- STOP, hold empty: return to IDLE.
- STOP, hold full: assert `ser_load` with the hold data, recompute parity from the hold data and its latched config, clear the hold, and go to START (back-to-back frames, no idle cycle).
- `Data_valid` while BUSY: handled as described under Configuration.
- `BUSY` = (state != IDLE).
- `ser_en` is 0 outside DATA. The serializer clears its counter whenever `ser_en` is low.

## Timing
- Reset values: state IDLE, `mux_sel`=01, `BUSY`/`ser_en`/`ser_load`/`tx_ovf`/`hold_full`/`par_bit`=0, `ser_pdata`=0.
- Frame length: 10 cycles without parity, 11 with. START begins the cycle after acceptance.
- `BUSY` rises in the START cycle and falls in the cycle after STOP. It stays high across back-to-back frames.
- A request arriving in the same cycle `BUSY` falls (IDLE) is accepted directly.
- `rst` mid-frame: next cycle is IDLE with the line high, and the hold buffer is cleared. The partial frame is abandoned and no `tx_ovf` pulse is produced.
- `ser_done` seen outside DATA is ignored.

## Configuration
- `UART_TX_HOLD_EN` defined:
  - One-entry holding register (data + PAR_EN + PAR_TYP).
  - `Data_valid` while BUSY and hold empty: capture, and `hold_full` rises next cycle.
  - Hold full: drop the request and pulse `tx_ovf`.
  - In STOP with the hold draining and `Data_valid`=1 in the same cycle: capture the new byte, no overflow.
- Not defined:
  - Every `Data_valid` while BUSY is dropped with a `tx_ovf` pulse.
  - `hold_full` is tied 0 and no hold registers exist.

## Structure
- Package `uart_tx_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the `mux_sel` encodings (`MUX_START`, `MUX_IDLE`, `MUX_DATA`, `MUX_PAR`);
  - the `DATA_WIDTH` default.
- Sub-module `uart_parity_calc`: combinational, inputs data and type, output parity bit. It is shared with the RX checker.
- The FSM, hold register and output decode all live in `uart_tx_ctrl`.

## Test plan
- 0xA5, PAR_EN=0 → `mux_sel` sequence 00, 10×8, 01. Line reads 0,1,0,1,0,0,1,0,1,1. BUSY high for 10 cycles.
- 0xA5 with PAR_EN=1 → `par_bit`=0 for PAR_TYP=0 and 1 for PAR_TYP=1. 11 cycles, with `mux_sel`=11 in cycle 10.
- `UART_TX_HOLD_EN`, send 0x3C, then 0xC3 at cycle 4 → 0xC3 `ser_load` in 0x3C's STOP cycle, START follows immediately, no `tx_ovf`.
- Three requests during one frame → third pulses `tx_ovf`. With the macro off, the second already pulses.
- `rst` asserted in DATA cycle 5 → next cycle IDLE, `mux_sel`=01, `ser_en`=0, `hold_full`=0.
- PAR_EN toggled mid-frame → current frame keeps its sampled parity config.
